// File: rtl/mem_msg_pkg.sv
// Shared definitions for the memory message channel: message lengths,
// payload field offsets and the port scheduler's state encoding.
package mem_msg_pkg;

  localparam logic [4:0] MSG_LEN_READ  = 5'd5;
  localparam logic [4:0] MSG_LEN_WRITE = 5'd9;
  localparam logic [4:0] MSG_LEN_REPLY = 5'd4;

  localparam int ADDR_LO = 32;
  localparam int MASK_LO = 64;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_RESP = 2'd2,
    ST_DONE      = 2'd3
  } state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/mem_rr_arb.sv
// Two-way round-robin arbiter: the port not served last wins a contention.
module mem_rr_arb #(
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic if_req_i,
  input  logic d_req_i,
  input  logic take_i,
  output logic gnt_d_o,
  output logic any_o
);

  logic ptr_q;
  logic ptr_d;

  assign any_o   = if_req_i | d_req_i;
  assign gnt_d_o = d_req_i & (ptr_q | ~if_req_i);

  // After a grant, priority moves to the other port (ptr_q=1: data has priority).
  always_comb begin
    ptr_d = ptr_q;
    if (take_i && any_o) begin
      ptr_d = ~gnt_d_o;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= DATA_FIRST;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Schedules the fetch and load/store ports onto one memory message channel:
// arbitration, message packing, send/receive handshake and reply return.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd65535,
  parameter bit          DATA_FIRST     = 1'b1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_mask,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        err,
  output logic        send_flag,
  output logic [4:0]  send_length,
  output logic [71:0] send_data,
  input  logic        sendable,
  output logic        recv_flag,
  input  logic [4:0]  recv_length,
  input  logic [71:0] recv_data,
  input  logic        recvable,
  output logic [7:0]  stray_cnt
);
  import mem_msg_pkg::*;

  localparam int CW = (TIMEOUT_CYCLES > 32'd1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 32'd1);

  state_e        state_q;
  logic          gnt_d_q;
  logic          we_q;
  logic [CW-1:0] tmo_q;
  logic [31:0]   if_rdata_q;
  logic [31:0]   d_rdata_q;
  logic          if_done_q;
  logic          d_done_q;
  logic          err_q;
  logic [4:0]    send_len_q;
  logic [71:0]   send_data_q;
  logic [7:0]    stray_q;

  logic          take_s;
  logic          arb_gnt_d_s;
  logic          arb_any_s;
  logic          skip_s;
  logic          reply_ok_s;
  logic [4:0]    msg_len_s;
  logic [71:0]   msg_data_s;
  logic          unused_recv_s;

  assign unused_recv_s = ^recv_data[71:32];

  // Replies pending in IDLE are drained as strays before any new grant.
  assign take_s     = (state_q == ST_IDLE) & ~recvable;
  assign skip_s     = arb_gnt_d_s & d_we & (d_mask == 4'd0);
  assign reply_ok_s = recvable & (recv_length == MSG_LEN_REPLY);

  mem_rr_arb #(
    .DATA_FIRST(DATA_FIRST)
  ) u_arb (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .if_req_i(if_req),
    .d_req_i (d_req),
    .take_i  (take_s),
    .gnt_d_o (arb_gnt_d_s),
    .any_o   (arb_any_s)
  );

  // Message image for whichever port the arbiter would grant this cycle.
  always_comb begin
    msg_len_s  = MSG_LEN_READ;
    msg_data_s = 72'd0;
    if (arb_gnt_d_s && d_we) begin
      msg_len_s                 = MSG_LEN_WRITE;
      msg_data_s[31:0]          = d_wdata;
      msg_data_s[ADDR_LO +: 32] = d_addr;
      msg_data_s[MASK_LO +: 4]  = d_mask;
    end else if (arb_gnt_d_s) begin
      msg_data_s[31:0] = d_addr;
    end else begin
      msg_data_s[31:0] = if_addr;
    end
  end

  // Scheduler FSM; done/err are set on entry to DONE so they pulse during it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      gnt_d_q     <= 1'b0;
      we_q        <= 1'b0;
      tmo_q       <= '0;
      if_rdata_q  <= 32'd0;
      d_rdata_q   <= 32'd0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      err_q       <= 1'b0;
      send_len_q  <= 5'd0;
      send_data_q <= 72'd0;
      stray_q     <= 8'd0;
    end else begin
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
      err_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (recvable) begin
            stray_q <= sat_inc8(stray_q);
          end else if (arb_any_s) begin
            gnt_d_q     <= arb_gnt_d_s;
            we_q        <= arb_gnt_d_s & d_we;
            send_len_q  <= msg_len_s;
            send_data_q <= msg_data_s;
            if (skip_s) begin
              state_q  <= ST_DONE;
              d_done_q <= 1'b1;
            end else begin
              state_q <= ST_SEND;
            end
          end
        end
        ST_SEND: begin
          if (sendable) begin
            if (we_q) begin
              state_q  <= ST_DONE;
              d_done_q <= 1'b1;
            end else begin
              state_q <= ST_WAIT_RESP;
              tmo_q   <= '0;
            end
          end
        end
        ST_WAIT_RESP: begin
          if (reply_ok_s) begin
            state_q <= ST_DONE;
            if (gnt_d_q) begin
              d_rdata_q <= recv_data[31:0];
              d_done_q  <= 1'b1;
            end else begin
              if_rdata_q <= recv_data[31:0];
              if_done_q  <= 1'b1;
            end
          end else begin
            if (recvable) begin
              stray_q <= sat_inc8(stray_q);
            end
            if (tmo_q == TMO_LAST) begin
              state_q <= ST_DONE;
              err_q   <= 1'b1;
              if (gnt_d_q) begin
                d_rdata_q <= 32'd0;
                d_done_q  <= 1'b1;
              end else begin
                if_rdata_q <= 32'd0;
                if_done_q  <= 1'b1;
              end
            end else begin
              tmo_q <= tmo_q + CW'(1);
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // The push/pop strobes qualify the channel's own ready bits in the same cycle.
  assign send_flag   = (state_q == ST_SEND) & sendable;
  assign recv_flag   = RST_N & recvable & ((state_q == ST_IDLE) | (state_q == ST_WAIT_RESP));
  assign send_length = send_len_q;
  assign send_data   = send_data_q;
  assign if_rdata    = if_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign if_done     = if_done_q;
  assign d_done      = d_done_q;
  assign err         = err_q;
  assign stray_cnt   = stray_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic, checked
// each cycle against a transaction-level reference model of the scheduler.
module tb_mem_port_arbiter;

  localparam int TMO = 16;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata, if_rdata, d_rdata;
  logic [3:0]  d_mask;
  logic        if_done, d_done, err;
  logic        send_flag, sendable, recv_flag, recvable;
  logic [4:0]  send_length, recv_length;
  logic [71:0] send_data, recv_data;
  logic [7:0]  stray_cnt;

  always #5 CLK = ~CLK;

  mem_port_arbiter #(.TIMEOUT_CYCLES(TMO), .DATA_FIRST(1'b1)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_we(d_we), .d_mask(d_mask), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .err(err),
    .send_flag(send_flag), .send_length(send_length), .send_data(send_data), .sendable(sendable),
    .recv_flag(recv_flag), .recv_length(recv_length), .recv_data(recv_data), .recvable(recvable),
    .stray_cnt(stray_cnt)
  );

  typedef struct {
    logic [4:0]  len;
    logic [71:0] data;
    int          t;
  } rep_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // reference model (phases: 0 free, 1 awaiting push, 2 awaiting reply, 3 completing)
  int          m_phase;
  bit          m_port_d, m_we, m_err, m_last_d;
  logic [4:0]  m_len;
  logic [71:0] m_msg;
  int          m_wait, m_stray;
  logic [31:0] m_if_rd, m_d_rd;

  // requesters and channel
  bit          if_pend, d_pend, d_w;
  logic [31:0] if_a, d_a, d_wd;
  logic [3:0]  d_m;
  bit          rst_v;
  rep_t        rq[$];
  bit          glog[$];
  int          send_mode, n_sends, d_req_cyc, d_done_cyc;
  bit          auto_req, auto_stray, auto_drop, drop_next, fixed_rd;
  logic [31:0] fixed_val;
  bit          seen_send_rd, seen_recv, last_d_err;
  logic [4:0]  last_len;
  logic [71:0] last_data;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_err = 0; m_stray = 0; m_if_rd = 32'd0; m_d_rd = 32'd0;
    m_last_d = 1'b0;  // data port first after reset
  endtask

  function automatic int sat(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  // What happens at a rising edge, given the inputs presented in the cycle before it.
  task automatic model_edge();
    bit pick_d;
    if (!RST_N) begin
      model_reset();
      return;
    end
    case (m_phase)
      0: begin
        if (recvable) m_stray = sat(m_stray);
        else if (if_req || d_req) begin
          pick_d = d_req && (!if_req || !m_last_d);
          m_last_d = pick_d;
          m_port_d = pick_d;
          m_err = 1'b0;
          m_we = pick_d && d_we;
          if (m_we) begin
            m_len = 5'd9;
            m_msg = {4'h0, d_mask, d_addr, d_wdata};
          end else begin
            m_len = 5'd5;
            m_msg = {40'h0, pick_d ? d_addr : if_addr};
          end
          m_phase = (m_we && d_mask == 4'd0) ? 3 : 1;
        end
      end
      1: if (sendable) begin m_phase = m_we ? 3 : 2; m_wait = 0; end
      2: begin
        m_wait++;
        if (recvable && recv_length == 5'd4) begin
          if (m_port_d) m_d_rd = recv_data[31:0]; else m_if_rd = recv_data[31:0];
          m_phase = 3;
        end else begin
          if (recvable) m_stray = sat(m_stray);
          if (m_wait >= TMO) begin
            m_err = 1'b1;
            if (m_port_d) m_d_rd = 32'd0; else m_if_rd = 32'd0;
            m_phase = 3;
          end
        end
      end
      default: m_phase = 0;
    endcase
  endtask

  task automatic drive();
    rep_t r;
    if (seen_recv && rq.size() > 0) rq.delete(0);
    if (seen_send_rd) begin
      if (drop_next) drop_next = 1'b0;
      else if (!(auto_drop && $urandom_range(0, 9) == 0)) begin
        r.len = 5'd4;
        r.data = {8'($urandom), 32'($urandom), fixed_rd ? fixed_val : 32'($urandom)};
        r.t = cyc + (auto_req ? int'($urandom_range(0, 4)) : 0);
        rq.push_back(r);
      end
    end
    if (auto_req) begin
      if (!if_pend && $urandom_range(0, 3) == 0) begin if_pend = 1'b1; if_a = $urandom; end
      if (!d_pend && $urandom_range(0, 3) == 0) begin
        d_pend = 1'b1; d_w = 1'($urandom); d_a = $urandom; d_wd = $urandom;
        d_m = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      end
    end
    if (auto_stray && rq.size() == 0 && $urandom_range(0, 29) == 0) begin
      r.len = 5'($urandom_range(5, 31)); r.data = {8'($urandom), 32'($urandom), 32'($urandom)}; r.t = cyc;
      rq.push_back(r);
    end
    RST_N = rst_v;
    if (d_pend && !d_req) d_req_cyc = cyc;
    if_req = if_pend; if_addr = if_a;
    d_req = d_pend; d_we = d_w; d_mask = d_m; d_addr = d_a; d_wdata = d_wd;
    sendable = (send_mode == 0) ? 1'b1 : (send_mode == 2) ? 1'b0 : ($urandom_range(0, 2) != 0);
    recvable = (rq.size() > 0) && (rq[0].t <= cyc);
    recv_length = recvable ? rq[0].len : 5'd0;
    recv_data = recvable ? rq[0].data : 72'd0;
  endtask

  task automatic observe();
    bit exp_send, exp_recv;
    if (!RST_N) model_reset();
    exp_send = (m_phase == 1) && sendable;
    exp_recv = RST_N && recvable && (m_phase == 0 || m_phase == 2);
    chk("send_flag", send_flag, exp_send);
    chk("recv_flag", recv_flag, exp_recv);
    chk("if_done", if_done, (m_phase == 3) && !m_port_d);
    chk("d_done", d_done, (m_phase == 3) && m_port_d);
    chk("err", err, (m_phase == 3) && m_err);
    chk("if_rdata", if_rdata, m_if_rd);
    chk("d_rdata", d_rdata, m_d_rd);
    chk("stray_cnt", stray_cnt, m_stray);
    if (exp_send) begin
      chk("send_length", send_length, m_len);
      chk("send_data", send_data, m_msg);
    end
    seen_send_rd = send_flag && send_length == 5'd5;
    seen_recv = recv_flag;
    if (send_flag) begin n_sends++; last_len = send_length; last_data = send_data; end
    if (if_done) begin if_pend = 1'b0; glog.push_back(1'b0); end
    if (d_done) begin d_pend = 1'b0; glog.push_back(1'b1); d_done_cyc = cyc; last_d_err = err; end
  endtask

  task automatic step();
    @(posedge CLK);
    cyc++;
    model_edge();
    #1;
    drive();
    @(negedge CLK);
    observe();
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((if_pend || d_pend) && n < budget) begin step(); n++; end
    chk(tag, {if_pend, d_pend}, 2'b00);
  endtask

  task automatic reset_pulse();
    rst_v = 1'b0; if_pend = 1'b0; d_pend = 1'b0;
    step(); step();
    rst_v = 1'b1;
    step();
  endtask

  initial begin
    rep_t r;
    RST_N = 1'b0; if_req = 0; d_req = 0; d_we = 0; d_mask = 0; if_addr = 0; d_addr = 0; d_wdata = 0;
    sendable = 0; recvable = 0; recv_length = 0; recv_data = 0;
    if_pend = 0; d_pend = 0; d_w = 0; if_a = 0; d_a = 0; d_wd = 0; d_m = 0; rst_v = 1'b0;
    send_mode = 0; auto_req = 0; auto_stray = 0; auto_drop = 0; drop_next = 0; fixed_rd = 0;
    seen_send_rd = 0; seen_recv = 0; n_sends = 0; model_reset();
    #2;
    observe();
    reset_pulse();

    // fetch read with a fixed reply
    fixed_rd = 1'b1; fixed_val = 32'hDEADBEEF;
    if_pend = 1'b1; if_a = 32'h100;
    wait_idle("rd_complete", 20);
    chk("rd_len", last_len, 5'd5);
    chk("rd_msg", last_data, 72'h100);
    chk("rd_if_rdata", if_rdata, 32'hDEADBEEF);
    fixed_rd = 1'b0;

    // full-mask write; done in the third cycle counting the request cycle
    d_pend = 1'b1; d_w = 1'b1; d_m = 4'hF; d_a = 32'h204; d_wd = 32'h11223344;
    wait_idle("wr_complete", 20);
    chk("wr_len", last_len, 5'd9);
    chk("wr_addr", last_data[63:32], 32'h204);
    chk("wr_mask", last_data[67:64], 4'hF);
    chk("wr_latency", d_done_cyc - d_req_cyc, 2);

    // contention from reset: D, I, D, I
    reset_pulse();
    glog.delete();
    d_w = 1'b0;
    for (int n = 0; n < 200 && glog.size() < 4; n++) begin
      if (!if_pend) begin if_pend = 1'b1; if_a = $urandom; end
      if (!d_pend) begin d_pend = 1'b1; d_a = $urandom; end
      step();
    end
    wait_idle("cont_drain", 40);
    chk("cont_count", glog.size() >= 4, 1'b1);
    for (int i = 0; i < 4 && i < glog.size(); i++) chk("cont_order", glog[i], (i % 2 == 0) ? 1'b1 : 1'b0);

    // back-pressure, then a wrong-length reply while waiting
    send_mode = 2; drop_next = 1'b1; n_sends = 0;
    if_pend = 1'b1; if_a = 32'h300;
    for (int i = 0; i < 10; i++) step();
    chk("bp_no_send", n_sends, 0);
    send_mode = 0;
    step(); step();
    chk("bp_one_send", n_sends, 1);
    r.len = 5'd9; r.data = 72'h55; r.t = cyc; rq.push_back(r);
    step(); step(); step();
    chk("bp_stray", stray_cnt, 8'd1);
    chk("bp_waiting", if_pend, 1'b1);
    r.len = 5'd4; r.data = 72'hCAFE0001; r.t = cyc; rq.push_back(r);
    wait_idle("bp_complete", 20);
    chk("bp_rdata", if_rdata, 32'hCAFE0001);

    // data read timeout
    drop_next = 1'b1;
    d_pend = 1'b1; d_w = 1'b0; d_a = 32'h400;
    wait_idle("tmo_complete", TMO + 20);
    chk("tmo_err", last_d_err, 1'b1);
    chk("tmo_rdata", d_rdata, 32'd0);
    chk("tmo_latency", d_done_cyc - d_req_cyc, TMO + 2);

    // reset while waiting; the late reply becomes a stray
    drop_next = 1'b1; glog.delete();
    if_pend = 1'b1; if_a = 32'h500;
    for (int i = 0; i < 5; i++) step();
    reset_pulse();
    r.len = 5'd4; r.data = 72'h77; r.t = cyc; rq.push_back(r);
    step(); step(); step();
    chk("rst_stray", stray_cnt, 8'd1);
    chk("rst_no_done", glog.size(), 0);

    // stray counter saturation
    for (int i = 0; i < 260; i++) begin r.len = 5'd3; r.data = 72'd0; r.t = cyc; rq.push_back(r); end
    for (int i = 0; i < 265; i++) step();
    chk("stray_sat", stray_cnt, 8'd255);

    // randomized traffic
    reset_pulse();
    auto_req = 1'b1; auto_stray = 1'b1; auto_drop = 1'b1; send_mode = 1;
    for (int i = 0; i < 3000; i++) step();
    auto_req = 1'b0; auto_stray = 1'b0;
    wait_idle("rand_drain", 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- CPU-side scheduler for the single UART memory channel.
- Shares one message channel between the instruction-fetch port and the load/store port. Encodes each granted request as a memory message and sequences it through the channel's send/receive handshake.
- Waits for the 4-byte read reply and returns the data to the requester that owns the grant.
- Sits between the CPU core and channel 0 of the multi-channel UART link.

Parameters:
- TIMEOUT_CYCLES, 65535, cycles to wait in WAIT_RESP before aborting a read with error.
- DATA_FIRST, 1, tie-break on the first contention after reset: 1 grants data port first, 0 grants fetch first.

Ports:
- CLK  in  1  system clock, all logic on rising edge
- RST_N  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held with if_addr stable until if_done
- if_addr  in  32  fetch byte address
- if_rdata  out  32  fetch data, valid when if_done=1
- if_done  out  1  one-cycle completion pulse for fetch
- d_req  in  1  data request; held with its signals stable until d_done
- d_we  in  1  1=write, 0=read
- d_mask  in  4  byte enables for a write; bit k covers byte k
- d_addr  in  32  data byte address
- d_wdata  in  32  write data
- d_rdata  out  32  load data, valid when d_done=1
- d_done  out  1  one-cycle completion pulse for data port
- err  out  1  one-cycle pulse with a done pulse when a read timed out; rdata=0 in that case
- send_flag  out  1  push one message to the channel
- send_length  out  5  message byte length
- send_data  out  72  message payload
- sendable  in  1  channel can accept a message this cycle
- recv_flag  out  1  pop one reply from the channel
- recv_length  in  5  reply byte length
- recv_data  in  72  reply payload
- recvable  in  1  reply available
- stray_cnt  out  8  saturating count of dropped replies

Behaviour:
- Reset: RST_N low forces, asynchronously:
  - state IDLE;
  - all done/err/send_flag/recv_flag outputs 0;
  - rdata outputs 0; stray_cnt 0;
  - round-robin pointer set per DATA_FIRST.
- Reset mid-transaction aborts it with no done pulse. A reply arriving afterwards is a stray.
- FSM states: IDLE, SEND, WAIT_RESP, DONE.
- IDLE behaviour:
  - if recvable, pop the reply (recv_flag=1), drop it, and increment stray_cnt (saturate at 255);
  - else if any req, grant; on contention, grant the port not served last, then flip the pointer;
  - at grant, latch port id, addr, we, mask, wdata, and go to SEND;
  - a write with mask=0 skips the channel and goes directly to DONE.
- SEND behaviour:
  - assert send_flag for exactly one cycle, in the first cycle with sendable=1; hold otherwise;
  - read message: send_length=5, send_data[31:0]=addr, all other bits 0;
  - write message: send_length=9, [31:0]=wdata, [63:32]=addr, [67:64]=mask, [71:68]=0;
  - after the push, a read goes to WAIT_RESP with the timeout counter cleared; a write goes to DONE, since writes get no reply.
- WAIT_RESP behaviour:
  - on recvable, pop it (recv_flag=1 for one cycle);
  - if recv_length==4, capture recv_data[31:0] and go to DONE;
  - any other length is dropped, stray_cnt increments, and the block keeps waiting;
  - if the counter reaches TIMEOUT_CYCLES, go to DONE with err and rdata=0.
- DONE: pulse the granted port's done for one cycle with its rdata, then go to IDLE.
- rdata outputs hold their last value between transactions.
- The same port may re-request in the cycle after done; it is arbitered normally.
- send_flag and recv_flag are never both high in one cycle.
- Best-case latency (sendable and recvable immediate):
  - write: done 3 cycles after req is sampled;
  - read: done 4 cycles plus the channel round trip.

Decomposition:
- Shared package mem_msg_pkg holds:
  - constants MSG_LEN_READ=5, MSG_LEN_WRITE=9, MSG_LEN_REPLY=4;
  - payload field offsets ADDR_LO=32 (write), MASK_LO=64;
  - the FSM state enum.
- One sub-module, mem_rr_arb: 2-way round-robin grant plus pointer.
- Message packing stays inline.

Test Plan:
- Fetch read: if_req, if_addr=0x100, sendable=1 → one send_flag with length 5, data=0x100. Then reply length 4, data 0xDEADBEEF → if_done pulse, if_rdata=0xDEADBEEF.
- Data write: d_we=1, d_addr=0x204, d_wdata=0x11223344, mask=0xF → length 9, data[63:32]=0x204, [67:64]=0xF. d_done 3 cycles after req, with no recv_flag.
- Contention: if_req and d_req both high for four transactions, DATA_FIRST=1 → grant order D, I, D, I.
- Back-pressure and stray: sendable=0 for 10 cycles → send_flag stays low, then pulses once. Reply of length 9 during WAIT_RESP → dropped, stray_cnt=1, still waiting.
- Timeout and reset: no reply with TIMEOUT_CYCLES=16 → err and d_done together, d_rdata=0. RST_N low in WAIT_RESP → all outputs 0; a later reply is dropped and stray_cnt increments.
